// File: rtl/servo_pwm_generator_pkg.sv
// MG995 servo timing constants and angle codes, shared with pwm_monitor.
package servo_pwm_generator_pkg;

    localparam int MG995_PERIOD_CLKS    = 1000000;
    localparam int MG995_ANGLE_0_CLKS   = 50000;
    localparam int MG995_ANGLE_90_CLKS  = 75000;
    localparam int MG995_ANGLE_180_CLKS = 100000;
    localparam int MG995_STEP_CLKS      = 5000;
    localparam int MG995_CNT_W          = 20;
    localparam int MG995_WIDTH_W        = 17;

    typedef enum logic [1:0] {
        SEL_OFF = 2'd0,
        SEL_0   = 2'd1,
        SEL_90  = 2'd2,
        SEL_180 = 2'd3
    } sel_e;

    localparam logic PWM_LOW  = 1'b0;
    localparam logic PWM_HIGH = 1'b1;

endpackage

// File: rtl/servo_period_counter.sv
// Free-running frame counter with boundary flag and registered frame-start pulse.
module servo_period_counter #(
    parameter int PERIOD_P = 1000000,
    parameter int CNT_W_P  = 20
) (
    input  logic               Clk_i,
    input  logic               Reset_i,
    output logic [CNT_W_P-1:0] Count_o,
    output logic               Boundary_o,
    output logic               Period_Start_o
);

    localparam logic [CNT_W_P-1:0] LAST_C = CNT_W_P'(PERIOD_P - 1);

    logic [CNT_W_P-1:0] cnt_q;
    logic               start_p1;

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            cnt_q    <= '0;
            start_p1 <= 1'b0;
        end else begin
            cnt_q    <= (cnt_q == LAST_C) ? '0 : cnt_q + 1'b1;
            start_p1 <= (cnt_q == '0);
        end
    end

    assign Count_o        = cnt_q;
    assign Boundary_o     = (cnt_q == LAST_C);
    assign Period_Start_o = start_p1;

endmodule

// File: rtl/servo_pwm_generator.sv
// MG995 servo PWM generator: one-deep command slot, frame-aligned width updates, per-frame slew limit.
module servo_pwm_generator
    import servo_pwm_generator_pkg::*;
#(
    parameter int PERIOD_P    = MG995_PERIOD_CLKS,
    parameter int ANGLE_0_P   = MG995_ANGLE_0_CLKS,
    parameter int ANGLE_90_P  = MG995_ANGLE_90_CLKS,
    parameter int ANGLE_180_P = MG995_ANGLE_180_CLKS,
    parameter int STEP_P      = MG995_STEP_CLKS,
    parameter int CNT_W_P     = MG995_CNT_W,
    parameter int WIDTH_W_P   = MG995_WIDTH_W
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    input  logic [1:0]           Sel_i,
    input  logic                 Sel_Valid_i,
    output logic                 Sel_Ready_o,
    output logic                 Pwm_o,
    output logic                 Period_Start_o,
    output logic [WIDTH_W_P-1:0] Duty_Cycle_o,
    output logic                 Busy_o
);

    localparam int CMP_W = (CNT_W_P > WIDTH_W_P) ? CNT_W_P : WIDTH_W_P;
    localparam logic [WIDTH_W_P-1:0] W_ANGLE_0   = WIDTH_W_P'(ANGLE_0_P);
    localparam logic [WIDTH_W_P-1:0] W_ANGLE_90  = WIDTH_W_P'(ANGLE_90_P);
    localparam logic [WIDTH_W_P-1:0] W_ANGLE_180 = WIDTH_W_P'(ANGLE_180_P);
    localparam logic [WIDTH_W_P:0]   STEP_X      = (WIDTH_W_P+1)'(STEP_P);

    function automatic logic [WIDTH_W_P-1:0] decode_width(input sel_e code);
        case (code)
            SEL_0:   decode_width = W_ANGLE_0;
            SEL_90:  decode_width = W_ANGLE_90;
            SEL_180: decode_width = W_ANGLE_180;
            default: decode_width = '0;
        endcase
    endfunction

    // One extra bit of headroom so neither the up nor the down step can wrap.
    function automatic logic [WIDTH_W_P-1:0] ramp_width(input logic [WIDTH_W_P-1:0] cur,
                                                        input logic [WIDTH_W_P-1:0] tgt);
        logic [WIDTH_W_P:0] cur_x;
        logic [WIDTH_W_P:0] tgt_x;
        logic [WIDTH_W_P:0] up_x;
        logic [WIDTH_W_P:0] dn_x;
        cur_x = {1'b0, cur};
        tgt_x = {1'b0, tgt};
        up_x  = cur_x + STEP_X;
        dn_x  = cur_x - STEP_X;
        if (tgt == '0)
            ramp_width = '0;
        else if (cur == '0)
            ramp_width = tgt;
        else if (cur_x < tgt_x)
            ramp_width = (up_x >= tgt_x) ? tgt : up_x[WIDTH_W_P-1:0];
        else if ((cur_x - tgt_x) > STEP_X)
            ramp_width = dn_x[WIDTH_W_P-1:0];
        else
            ramp_width = tgt;
    endfunction

    logic [CNT_W_P-1:0]   count;
    logic                 boundary;
    logic                 xfer;
    logic                 pend_q;
    sel_e                 pend_code_q;
    logic [WIDTH_W_P-1:0] target_q;
    logic [WIDTH_W_P-1:0] active_q;
    logic [WIDTH_W_P-1:0] new_target;
    logic [WIDTH_W_P-1:0] next_active;
    logic [CMP_W-1:0]     count_x;
    logic [CMP_W-1:0]     active_x;
    logic                 pwm_p1;
    logic                 busy_p1;

    servo_period_counter #(
        .PERIOD_P (PERIOD_P),
        .CNT_W_P  (CNT_W_P)
    ) u_period_counter (
        .Clk_i          (Clk_i),
        .Reset_i        (Reset_i),
        .Count_o        (count),
        .Boundary_o     (boundary),
        .Period_Start_o (Period_Start_o)
    );

    assign xfer        = Sel_Valid_i && !pend_q;
    assign new_target  = pend_q ? decode_width(pend_code_q) : target_q;
    assign next_active = ramp_width(active_q, new_target);
    assign count_x     = CMP_W'(count);
    assign active_x    = CMP_W'(active_q);

    // Command slot and frame-boundary width update
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            pend_q      <= 1'b0;
            pend_code_q <= SEL_OFF;
            target_q    <= '0;
            active_q    <= '0;
        end else begin
            if (xfer)
                pend_code_q <= sel_e'(Sel_i);
            if (boundary) begin
                target_q <= new_target;
                active_q <= next_active;
                pend_q   <= xfer;
            end else if (xfer) begin
                pend_q <= 1'b1;
            end
        end
    end

    // Registered outputs, one cycle behind the counter
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            pwm_p1  <= PWM_LOW;
            busy_p1 <= 1'b0;
        end else begin
            pwm_p1  <= (count_x < active_x) ? PWM_HIGH : PWM_LOW;
            busy_p1 <= pend_q || (active_q != target_q);
        end
    end

    assign Pwm_o        = pwm_p1;
    assign Busy_o       = busy_p1;
    assign Duty_Cycle_o = active_q;
    assign Sel_Ready_o  = !pend_q;

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Bench for servo_pwm_generator at reduced timing: directed frame scenarios plus randomized commands vs a cycle model.
module tb_servo_pwm_generator;

    localparam int PER  = 200;
    localparam int A0   = 20;
    localparam int A90  = 30;
    localparam int A180 = 40;
    localparam int STEP = 5;
    localparam int CW   = 8;
    localparam int WW   = 7;

    logic          Clk_i = 1'b0;
    logic          Reset_i = 1'b0;
    logic [1:0]    Sel_i = 2'd0;
    logic          Sel_Valid_i = 1'b0;
    logic          Sel_Ready_o;
    logic          Pwm_o;
    logic          Period_Start_o;
    logic [WW-1:0] Duty_Cycle_o;
    logic          Busy_o;

    int checks = 0;
    int failures = 0;

    servo_pwm_generator #(
        .PERIOD_P    (PER),
        .ANGLE_0_P   (A0),
        .ANGLE_90_P  (A90),
        .ANGLE_180_P (A180),
        .STEP_P      (STEP),
        .CNT_W_P     (CW),
        .WIDTH_W_P   (WW)
    ) dut (
        .Clk_i          (Clk_i),
        .Reset_i        (Reset_i),
        .Sel_i          (Sel_i),
        .Sel_Valid_i    (Sel_Valid_i),
        .Sel_Ready_o    (Sel_Ready_o),
        .Pwm_o          (Pwm_o),
        .Period_Start_o (Period_Start_o),
        .Duty_Cycle_o   (Duty_Cycle_o),
        .Busy_o         (Busy_o)
    );

    initial forever #5 Clk_i = ~Clk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: cycle index since reset, frame position, and the per-frame width rules.
    int m_k, m_active, m_target, m_code, m_pos, m_nt;
    bit m_pend, m_xfer, e_ps, e_pwm, e_busy;

    function automatic int angle_of(input int code);
        case (code)
            1: return A0;
            2: return A90;
            3: return A180;
            default: return 0;
        endcase
    endfunction

    function automatic int step_toward(input int a, input int t);
        if (t == 0) return 0;
        if (a == 0) return t;
        if (a < t) return (a + STEP < t) ? a + STEP : t;
        if (a > t) return (a - STEP > t) ? a - STEP : t;
        return t;
    endfunction

    assign m_pos  = m_k % PER;
    assign m_nt   = m_pend ? angle_of(m_code) : m_target;
    assign m_xfer = Sel_Valid_i && !m_pend;

    always @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            m_k <= 0; m_active <= 0; m_target <= 0; m_code <= 0; m_pend <= 1'b0;
            e_ps <= 1'b0; e_pwm <= 1'b0; e_busy <= 1'b0;
        end else begin
            e_ps   <= (m_pos == 0);
            e_pwm  <= (m_pos < m_active);
            e_busy <= m_pend || (m_active != m_target);
            m_k    <= m_k + 1;
            if (m_pos == PER - 1) begin
                m_active <= step_toward(m_active, m_nt);
                m_target <= m_nt;
                m_pend   <= m_xfer;
            end else if (m_xfer) begin
                m_pend <= 1'b1;
            end
            if (m_xfer) m_code <= int'(Sel_i);
        end
    end

    task automatic wait_ps();
        for (int i = 0; i <= PER + 1; i++) begin
            @(negedge Clk_i);
            if (Period_Start_o === 1'b1) return;
        end
        $display("FAIL wait_ps: no Period_Start_o within %0d cycles, required one", PER + 2);
        $fatal(1, "no frame start");
    endtask

    task automatic send(input logic [1:0] s);
        int n;
        n = 0;
        while (Sel_Ready_o !== 1'b1) begin
            @(negedge Clk_i);
            n++;
            if (n > 2 * PER) begin
                $display("FAIL send: Sel_Ready_o stuck at %b, required 1", Sel_Ready_o);
                $fatal(1, "ready timeout");
            end
        end
        Sel_i = s;
        Sel_Valid_i = 1'b1;
        @(negedge Clk_i);
        Sel_Valid_i = 1'b0;
    endtask

    // Called on the negedge where Period_Start_o is high; returns on the next frame's start negedge.
    task automatic measure_frame(output int hi, output bit contig, output int duty, output bit busy0);
        hi = 0; contig = 1'b1; duty = int'(Duty_Cycle_o); busy0 = Busy_o;
        for (int i = 0; i < PER; i++) begin
            if (i > 0) @(negedge Clk_i);
            if (Pwm_o !== 1'b0) begin
                if (hi != i) contig = 1'b0;
                hi++;
            end
        end
        @(negedge Clk_i);
    endtask

    task automatic check_idle_frames();
        int last, nps, hi, bad_int, bad_st;
        last = 0; nps = 0; hi = 0; bad_int = 0; bad_st = 0;
        @(negedge Clk_i);
        checks++;
        if (Period_Start_o !== 1'b1) begin
            failures++;
            $display("FAIL first_period_start: got %b, required 1", Period_Start_o);
        end
        for (int i = 1; i <= 3 * PER; i++) begin
            @(negedge Clk_i);
            if (Period_Start_o === 1'b1) begin
                if (i - last != PER) bad_int++;
                last = i; nps++;
            end
            if (Pwm_o !== 1'b0) hi++;
            if (Duty_Cycle_o !== '0 || Busy_o !== 1'b0 || Sel_Ready_o !== 1'b1) bad_st++;
        end
        checks++;
        if (nps != 3 || bad_int != 0) begin
            failures++;
            $display("FAIL idle_period: starts=%0d bad_spacing=%0d, required 3 starts every %0d", nps, bad_int, PER);
        end
        checks++;
        if (hi != 0) begin
            failures++;
            $display("FAIL idle_pwm: high cycles=%0d, required 0", hi);
        end
        checks++;
        if (bad_st != 0) begin
            failures++;
            $display("FAIL idle_status: %0d cycles with duty!=0/busy!=0/ready!=1, required 0", bad_st);
        end
    endtask

    task automatic test_reset();
        Reset_i = 1'b0; Sel_Valid_i = 1'b0; Sel_i = 2'd0;
        repeat (3) @(negedge Clk_i);
        checks++;
        if ({Pwm_o, Period_Start_o, Busy_o, Sel_Ready_o} !== 4'b0001 || Duty_Cycle_o !== '0) begin
            failures++;
            $display("FAIL reset_values: pwm/ps/busy/ready=%b duty=%0d, required 0001 duty=0",
                     {Pwm_o, Period_Start_o, Busy_o, Sel_Ready_o}, Duty_Cycle_o);
        end
        Reset_i = 1'b1;
        check_idle_frames();
    endtask

    task automatic test_turn_on();
        int hi, duty; bit contig, busy0;
        repeat (50) @(negedge Clk_i);
        send(2'd2);
        checks++;
        if (Sel_Ready_o !== 1'b0) begin
            failures++;
            $display("FAIL on_ready_low: got %b, required 0", Sel_Ready_o);
        end
        wait_ps();
        checks++;
        if (Sel_Ready_o !== 1'b1) begin
            failures++;
            $display("FAIL on_ready_back: got %b, required 1", Sel_Ready_o);
        end
        measure_frame(hi, contig, duty, busy0);
        checks++;
        if (hi != A90 || !contig || duty != A90) begin
            failures++;
            $display("FAIL on_width: high=%0d contig=%0d duty=%0d, required %0d 1 %0d", hi, contig, duty, A90, A90);
        end
    endtask

    task automatic test_ramp();
        int hi, duty; bit contig, busy0;
        repeat (20) @(negedge Clk_i);
        send(2'd1);
        wait_ps();
        measure_frame(hi, contig, duty, busy0);
        checks++;
        if (hi != 25 || !contig || !busy0) begin
            failures++;
            $display("FAIL ramp_down1: high=%0d contig=%0d busy=%0d, required 25 1 1", hi, contig, busy0);
        end
        measure_frame(hi, contig, duty, busy0);
        checks++;
        if (hi != A0 || !contig || busy0) begin
            failures++;
            $display("FAIL ramp_down2: high=%0d contig=%0d busy=%0d, required %0d 1 0", hi, contig, busy0, A0);
        end
        repeat (20) @(negedge Clk_i);
        send(2'd3);
        wait_ps();
        for (int j = 0; j < 4; j++) begin
            measure_frame(hi, contig, duty, busy0);
            checks++;
            if (hi != 25 + 5 * j || duty != 25 + 5 * j || !contig || busy0 != (j < 3)) begin
                failures++;
                $display("FAIL ramp_up[%0d]: high=%0d duty=%0d contig=%0d busy=%0d, required %0d %0d 1 %0d",
                         j, hi, duty, contig, busy0, 25 + 5 * j, 25 + 5 * j, j < 3);
            end
        end
    endtask

    task automatic test_back_to_back();
        int hi, duty, n; bit contig, busy0;
        int exp_w[5] = '{40, 35, 30, 25, 20};
        repeat (30) @(negedge Clk_i);
        Sel_i = 2'd3; Sel_Valid_i = 1'b1;
        @(negedge Clk_i);
        Sel_i = 2'd1;
        checks++;
        if (Sel_Ready_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_held: ready=%b, required 0", Sel_Ready_o);
        end
        n = 0;
        while (Sel_Ready_o !== 1'b1) begin
            @(negedge Clk_i);
            n++;
            if (n > 2 * PER) begin
                $display("FAIL b2b_wait: ready never returned, required 1 by boundary");
                $fatal(1, "ready timeout");
            end
        end
        checks++;
        if (Period_Start_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_slot: ps=%b when ready returned, required 0", Period_Start_o);
        end
        @(negedge Clk_i);
        checks++;
        if (Period_Start_o !== 1'b1 || Sel_Ready_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: ps=%b ready=%b, required 1 0", Period_Start_o, Sel_Ready_o);
        end
        Sel_Valid_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            measure_frame(hi, contig, duty, busy0);
            checks++;
            if (hi != exp_w[j] || duty != exp_w[j] || !contig) begin
                failures++;
                $display("FAIL b2b_frame[%0d]: high=%0d duty=%0d contig=%0d, required %0d %0d 1",
                         j, hi, duty, contig, exp_w[j], exp_w[j]);
            end
        end
        checks++;
        if (Busy_o !== 1'b0 || Duty_Cycle_o !== WW'(A0)) begin
            failures++;
            $display("FAIL b2b_settled: busy=%b duty=%0d, required 0 %0d", Busy_o, Duty_Cycle_o, A0);
        end
    endtask

    task automatic test_turn_off();
        int hi, duty; bit contig, busy0;
        repeat (30) @(negedge Clk_i);
        send(2'd0);
        wait_ps();
        repeat (30) @(negedge Clk_i);
        send(2'd3);
        wait_ps();
        hi = 0; contig = 1'b1;
        for (int i = 0; i < PER; i++) begin
            if (i > 0) @(negedge Clk_i);
            if (i == 10) begin Sel_i = 2'd0; Sel_Valid_i = 1'b1; end
            if (i == 11) begin
                Sel_Valid_i = 1'b0;
                checks++;
                if (Sel_Ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL off_accepted: ready=%b, required 0", Sel_Ready_o);
                end
            end
            if (Pwm_o !== 1'b0) begin
                if (hi != i) contig = 1'b0;
                hi++;
            end
        end
        checks++;
        if (hi != A180 || !contig) begin
            failures++;
            $display("FAIL off_pulse_completes: high=%0d contig=%0d, required %0d 1", hi, contig, A180);
        end
        @(negedge Clk_i);
        measure_frame(hi, contig, duty, busy0);
        checks++;
        if (hi != 0 || duty != 0) begin
            failures++;
            $display("FAIL off_frame: high=%0d duty=%0d, required 0 0", hi, duty);
        end
    endtask

    task automatic test_reset_mid();
        repeat (40) @(negedge Clk_i);
        send(2'd2);
        wait_ps();
        repeat (15) @(negedge Clk_i);
        checks++;
        if (Pwm_o !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_pwm: got %b, required 1", Pwm_o);
        end
        #2 Reset_i = 1'b0;
        #1;
        checks++;
        if ({Pwm_o, Period_Start_o, Busy_o, Sel_Ready_o} !== 4'b0001 || Duty_Cycle_o !== '0) begin
            failures++;
            $display("FAIL async_reset: pwm/ps/busy/ready=%b duty=%0d, required 0001 duty=0",
                     {Pwm_o, Period_Start_o, Busy_o, Sel_Ready_o}, Duty_Cycle_o);
        end
        repeat (5) @(negedge Clk_i);
        Reset_i = 1'b1;
        check_idle_frames();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 8 * PER; c++) begin
            @(negedge Clk_i);
            checks++;
            if (Pwm_o !== e_pwm || Period_Start_o !== e_ps || Busy_o !== e_busy ||
                Sel_Ready_o !== !m_pend || Duty_Cycle_o !== WW'(m_active)) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random[%0d]: pwm/ps/busy/ready=%b%b%b%b duty=%0d, required %b%b%b%b duty=%0d",
                             c, Pwm_o, Period_Start_o, Busy_o, Sel_Ready_o, Duty_Cycle_o,
                             e_pwm, e_ps, e_busy, !m_pend, m_active);
                bad++;
            end
            Sel_Valid_i = ($urandom_range(0, 39) == 0);
            Sel_i = 2'($urandom_range(0, 3));
        end
        Sel_Valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_turn_on();
        test_ramp();
        test_back_to_back();
        test_turn_off();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servo_pwm_generator.md
Name: servo_pwm_generator

Overview:
- Produces the MG995 servo PWM waveform consumed by pwm_monitor: fixed 20 ms frame, high time selected by a 2-bit angle code.
- Angle commands enter through a one-deep valid/ready handshake and take effect only at frame boundaries, so no runt or glitched pulses occur.
- Width changes between non-zero angles are slew-limited per frame. This protects the servo gearbox and gives the monitor clean, repeatable widths.

Parameters:
- PERIOD_P, 1000000, clocks per frame (20 ms at 50 MHz).
- ANGLE_0_P, 50000, high clocks for code 1 (1.0 ms).
- ANGLE_90_P, 75000, high clocks for code 2 (1.5 ms).
- ANGLE_180_P, 100000, high clocks for code 3 (2.0 ms).
- STEP_P, 5000, maximum width change per frame (clocks).
- CNT_W_P, 20, frame counter width.
- WIDTH_W_P, 17, pulse-width register width.

Ports:
- Clk_i  in  1  system clock
- Reset_i  in  1  asynchronous, active-low reset
- Sel_i  in  2  angle code: 0 = off, 1 = 0°, 2 = 90°, 3 = 180°
- Sel_Valid_i  in  1  command valid
- Sel_Ready_o  out  1  command slot free
- Pwm_o  out  1  servo PWM, registered
- Period_Start_o  out  1  one-cycle pulse at start of each frame
- Duty_Cycle_o  out  WIDTH_W_P  width applied in the current frame
- Busy_o  out  1  command pending, or applied width not yet equal to target

Behaviour:
- Reset values: Pwm_o = 0, Period_Start_o = 0, Duty_Cycle_o = 0, Busy_o = 0, Sel_Ready_o = 1. Frame counter, target and pending register all clear to 0 (off).
- Frame counter:
  - Counts 0..PERIOD_P-1 and wraps; free-running, including while off.
  - Boundary cycle is count == PERIOD_P-1.
- Outputs registered from counter state:
  - Period_Start_o = 1 in the cycle after count == 0 is observed.
  - Pwm_o = 1 while count < active width (also registered), so Pwm_o rises in the same cycle as Period_Start_o.
  - High time is exactly active-width clocks. Width 0 means Pwm_o stays low for the whole frame.
- Handshake:
  - Transfer occurs when Sel_Valid_i && Sel_Ready_o; Sel_i is latched into pending and the pending flag is set.
  - Sel_Ready_o = !pending flag.
  - A transfer in the boundary cycle goes to pending and applies at the next boundary (latency of one frame).
  - Sel_i is ignored when not transferred.
- At each boundary:
  - new_target = pending ? decode(pending code) : target. Target is updated and pending is cleared.
  - Active width update:
    - new_target == 0: active = 0 immediately.
    - active == 0 and new_target != 0: active = new_target (no ramp from off).
    - active < new_target: active = min(active + STEP_P, new_target).
    - active > new_target: active = max(active − STEP_P, new_target).
  - Computed at WIDTH_W_P+1 bits; no wrap.
- The new active width governs the frame that starts on the next cycle. Duty_Cycle_o = active width.
- A command arriving mid-frame never alters the pulse already in progress.
- Busy_o = pending flag || (active != target), registered.
- Reset asserted mid-frame: all outputs go to reset values asynchronously. After release, the counter restarts at 0 and the first Period_Start_o follows on the next cycle.

Decomposition:
- Shared mg995 parameter include holds: PERIOD_P, angle clock counts, STEP_P, widths, Sel code values, low/high constants. These are shared with pwm_monitor.
- One sub-module, servo_period_counter: frame counter, boundary flag and Period_Start_o. The width/ramp logic stays in the top.

Test Plan:
Overrides for all tests: PERIOD_P=200, ANGLE_0_P=20, ANGLE_90_P=30, ANGLE_180_P=40, STEP_P=5, CNT_W_P=8, WIDTH_W_P=7.
1. Reset release, no commands -> Period_Start_o every 200 cycles, Pwm_o constantly 0, Duty_Cycle_o = 0, Sel_Ready_o = 1, Busy_o = 0.
2. Sel=2 accepted mid-frame while off -> Sel_Ready_o low until boundary. Next frame Pwm_o high exactly 30 cycles, aligned with Period_Start_o. Duty_Cycle_o = 30.
3. From width 20, Sel=3 -> successive frames 25, 30, 35, 40. Busy_o high until the frame with width 40 begins, then 0.
4. Two back-to-back commands (3 then 1) -> second held (Sel_Ready_o = 0) until boundary and accepted the cycle after. Target ends at 20; no frame shows a partial width.
5. Sel=0 accepted 10 cycles into a 40-cycle pulse -> current pulse completes at 40. Following frame Pwm_o = 0 and Duty_Cycle_o = 0.
6. Reset_i low 15 cycles into a pulse -> Pwm_o drops the same clock edge-independent instant. After release, state is as in scenario 1.
